// File: rtl/dbg_pkg.sv
// -----------------------------------------------------------------------------
// dbg_pkg
// Shared types and constants for the register debug view.
//   NUM_REGS     architectural integer registers tracked (x0..x31)
//   XLEN         register width
//   IDX_W        width of a register index
//   trk_state_t  tracker FSM states
//   word_t       one register value
//   reg_idx_t    one register index
// -----------------------------------------------------------------------------
package dbg_pkg;

  localparam int NUM_REGS = 32;
  localparam int XLEN     = 32;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    INIT,   // sweeping zeros into the shadow RAM after reset
    IDLE,   // waiting for the next frame start
    PRIME,  // first RAM read in flight
    COPY    // one register lands in the snapshot per cycle
  } trk_state_t;

  typedef logic [XLEN-1:0]  word_t;
  typedef logic [IDX_W-1:0] reg_idx_t;

  // Index of the last register; terminates both the INIT sweep and the COPY.
  localparam reg_idx_t LAST_IDX = reg_idx_t'(NUM_REGS - 1);

endpackage

// File: rtl/reg_shadow_ram.sv
// -----------------------------------------------------------------------------
// reg_shadow_ram
// 32x32 simple dual-port RAM shadowing the core register file.
// Ports:
//   clk    in   clock
//   we     in   write strobe
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address (sampled on clk)
//   rdata  out  registered read data, one cycle after raddr
// A read and a write to the same address on the same edge return the old
// contents. The array has no reset.
// -----------------------------------------------------------------------------
module reg_shadow_ram
  import dbg_pkg::*;
(
  input  logic     clk,
  input  logic     we,
  input  reg_idx_t waddr,
  input  word_t    wdata,
  input  reg_idx_t raddr,
  output word_t    rdata
);

  word_t mem [0:NUM_REGS-1];

  // NOTE: the array is deliberately left out of any reset so it maps onto
  // RAM primitives; the tracker's INIT sweep is what gives it known contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    // NOTE: non-blocking assignment here is what makes a same-edge collision
    // read the pre-write value; a blocking write would forward the new data.
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/reg_debug_tracker.sv
// -----------------------------------------------------------------------------
// reg_debug_tracker
// Write side of the register debug view. Snoops core register writeback into
// a shadow RAM, copies the RAM into regs_out once per frame, and keeps a
// per-register highlight mask that stays set for HOLD_FRAMES accepted frames
// after each write.
//
// Parameters:
//   HOLD_FRAMES  frames a register stays highlighted after a write (1..255)
//   HOLD_W       width of each hold counter (derived)
// Ports:
//   clk           in   pixel clock (also clocks the core debug port)
//   reset         in   synchronous, active-high reset
//   wb_we         in   core register-file write strobe
//   wb_rd         in   destination register index
//   wb_data       in   write data
//   frame_start   in   one-cycle pulse at the start of vertical blank
//   freeze        in   hold the display (only with REGTRK_FREEZE_EN defined)
//   regs_out      out  snapshot of x0..x31 fed to the display
//   changed_mask  out  bit i set while register i is highlighted
//   busy          out  high while in INIT, PRIME or COPY
//
// Build option: define REGTRK_FREEZE_EN to add the freeze port. While freeze
// is high a frame start is not accepted (no copy, mask and counters held),
// but writes still reach the RAM and still reload their hold counters.
//
// Timing for a frame start accepted at edge T: the read of register 0 is
// issued at T, PRIME covers T+1, and regs_out[k] loads at edge T+2+k. The FSM
// returns to IDLE at edge T+33, where busy also drops.
// -----------------------------------------------------------------------------
module reg_debug_tracker
  import dbg_pkg::*;
#(
  parameter int HOLD_FRAMES = 4,
  parameter int HOLD_W      = $clog2(HOLD_FRAMES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_we,
  input  logic [IDX_W-1:0]     wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 frame_start,
`ifdef REGTRK_FREEZE_EN
  input  logic                 freeze,
`endif
  output word_t                regs_out [0:NUM_REGS-1],
  output logic [NUM_REGS-1:0]  changed_mask,
  output logic                 busy
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  trk_state_t        state;
  reg_idx_t          idx;       // INIT sweep address, then COPY destination
  reg_idx_t          rd_addr;   // RAM read address, runs one ahead of idx
  logic [HOLD_W-1:0] cnt [NUM_REGS];

  // ---------------------------------------------------------------------------
  // Accept decisions
  // ---------------------------------------------------------------------------
  logic frozen;
`ifdef REGTRK_FREEZE_EN
  assign frozen = freeze;
`else
  assign frozen = 1'b0;
`endif

  // x0 is hardwired to zero in the core, so writes to it are never tracked.
  logic wb_accept;
  logic frame_accept;

  assign wb_accept    = (state != INIT) && wb_we && (wb_rd != '0);
  assign frame_accept = (state == IDLE) && frame_start && !frozen;

  // ---------------------------------------------------------------------------
  // Shadow RAM write-port mux: the INIT sweep owns the port, otherwise the
  // core writeback does. wb_accept is already low during INIT.
  // ---------------------------------------------------------------------------
  logic     ram_we;
  reg_idx_t ram_waddr;
  word_t    ram_wdata;
  word_t    ram_rdata;

  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    ram_we    = wb_accept;
    ram_waddr = wb_rd;
    ram_wdata = wb_data;
    if (state == INIT) begin
      ram_we    = 1'b1;
      ram_waddr = idx;
      ram_wdata = '0;
    end
  end

  reg_shadow_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // FSM with registered busy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= INIT;
      idx     <= '0;
      rd_addr <= '0;
      busy    <= 1'b1;
    end else begin
      unique case (state)
        INIT: begin
          if (idx == LAST_IDX) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        IDLE: begin
          if (frame_accept) begin
            state   <= PRIME;
            idx     <= '0;
            rd_addr <= '0;
            busy    <= 1'b1;
          end
        end

        // The read of register 0 completes at this edge; start the next one.
        PRIME: begin
          state   <= COPY;
          rd_addr <= rd_addr + 1'b1;
        end

        // rd_addr wraps past 31 on the final cycle; that read is never used.
        COPY: begin
          rd_addr <= rd_addr + 1'b1;
          if (idx == LAST_IDX) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        default: begin
          state <= INIT;
          idx   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot registers. A reset mid-COPY discards the partial snapshot.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_out[k] <= '0;
      end
    end else if (state == COPY) begin
      regs_out[idx] <= ram_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Highlight mask and hold counters. The mask samples the counters before
  // they decrement, and a write in the same cycle reloads its counter in
  // preference to the decrement, so a written register is highlighted for
  // exactly HOLD_FRAMES accepted frames.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      changed_mask <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb_accept && (wb_rd == reg_idx_t'(i))) begin
          cnt[i] <= HOLD_LOAD;
        end else if (frame_accept && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
        if (frame_accept) begin
          changed_mask[i] <= (cnt[i] != '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_debug_tracker.sv
// -----------------------------------------------------------------------------
// tb_reg_debug_tracker
// Scoreboard bench for reg_debug_tracker. The driver keeps a behavioural
// model of the architectural registers, their highlight lifetimes and the
// tracker's availability; each accepted frame produces an expected snapshot,
// mask and completion edge that is queued for the monitor, which compares
// whenever busy falls. Build with REGTRK_FREEZE_EN to exercise freeze.
// -----------------------------------------------------------------------------
module tb_reg_debug_tracker;
  import dbg_pkg::*;

  localparam int HOLD        = 4;
  localparam int INIT_CYCLES = NUM_REGS;   // edges spent clearing the RAM
  localparam int COPY_SPAN   = NUM_REGS + 1; // accept edge -> busy-falling edge
`ifdef REGTRK_FREEZE_EN
  localparam bit FRZ = 1'b1;
`else
  localparam bit FRZ = 1'b0;
`endif

  typedef logic [NUM_REGS-1:0][XLEN-1:0] snap_vec_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                wb_we = 1'b0;
  logic [IDX_W-1:0]    wb_rd = '0;
  word_t               wb_data = '0;
  logic                frame_start = 1'b0;
`ifdef REGTRK_FREEZE_EN
  logic                freeze = 1'b0;
`endif
  word_t               regs_out [0:NUM_REGS-1];
  logic [NUM_REGS-1:0] changed_mask;
  logic                busy;

  always #5 clk = ~clk;

  reg_debug_tracker #(.HOLD_FRAMES(HOLD)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .frame_start  (frame_start),
`ifdef REGTRK_FREEZE_EN
    .freeze       (freeze),
`endif
    .regs_out     (regs_out),
    .changed_mask (changed_mask),
    .busy         (busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  word_t       mdl_regs [NUM_REGS];
  int          hold     [NUM_REGS];
  int          edge_n;      // edges since reset release
  int          free_edge;   // first edge at which a frame start can be taken
  int          copy_base;   // accept edge of the copy in progress, -1 if none
  snap_vec_t   cur_snap;
  logic [31:0] cur_mask;

  snap_vec_t   exp_regs_q [$];
  logic [31:0] exp_mask_q [$];
  int          exp_fall_q [$];

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      mdl_regs[i] = '0;
      hold[i]     = 0;
    end
    edge_n    = 0;
    free_edge = INIT_CYCLES;
    copy_base = -1;
    cur_snap  = '0;
    cur_mask  = '0;
    exp_regs_q.delete();
    exp_mask_q.delete();
    exp_fall_q.delete();
  endtask

  // Applies one clock edge's worth of inputs to the model. Register k of a
  // frame accepted at T is read at edge T+1+k and sees every write made at
  // earlier edges, but not one made at that same edge.
  task automatic model_edge(input logic we, input logic [IDX_W-1:0] rd, input word_t d,
                            input logic fs, input logic fz);
    int k;
    bit accept;
    if (copy_base >= 0) begin
      k = edge_n - copy_base - 1;
      if (k >= 0 && k < NUM_REGS) cur_snap[k] = mdl_regs[k];
      if (k == NUM_REGS - 1) begin
        exp_regs_q.push_back(cur_snap);
        exp_mask_q.push_back(cur_mask);
        exp_fall_q.push_back(copy_base + COPY_SPAN);
        copy_base = -1;
      end
    end
    accept = fs && !(fz && FRZ) && (edge_n >= free_edge);
    if (accept) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cur_mask[i] = (hold[i] != 0);
        if (hold[i] > 0) hold[i]--;
      end
      copy_base = edge_n;
      free_edge = edge_n + COPY_SPAN + 1;
    end
    if (edge_n >= INIT_CYCLES && we && rd != '0) begin
      mdl_regs[rd] = d;
      hold[rd]     = HOLD;
    end
    edge_n++;
  endtask

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic step(input logic we, input logic [IDX_W-1:0] rd, input word_t d,
                      input logic fs, input logic fz);
    wb_we       = we;
    wb_rd       = rd;
    wb_data     = d;
    frame_start = fs;
`ifdef REGTRK_FREEZE_EN
    freeze      = fz;
`endif
    @(posedge clk);
    model_edge(we, rd, d, fs, fz);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic frame();
    step(1'b0, '0, '0, 1'b1, 1'b0);
    idle(COPY_SPAN);
  endtask

  task automatic check_all_zero(input string name);
    int bad;
    bad = 0;
    for (int k = NUM_REGS - 1; k >= 0; k--) if (regs_out[k] !== '0) bad = k;
    check($sformatf("%s x%0d", name, bad), regs_out[bad], 32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares a queued expectation each time busy falls
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic        prev_busy;
    int          last;
    int          bad;
    snap_vec_t   s;
    logic [31:0] m;
    int          f;
    prev_busy = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b1;
      end else begin
        last = edge_n - 1;
        if (exp_fall_q.size() > 0 && last > exp_fall_q[0]) begin
          check("copy_done_timeout", last, exp_fall_q[0]);
          void'(exp_regs_q.pop_front());
          void'(exp_mask_q.pop_front());
          void'(exp_fall_q.pop_front());
        end
        if (prev_busy && !busy) begin
          if (exp_fall_q.size() > 0) begin
            s = exp_regs_q.pop_front();
            m = exp_mask_q.pop_front();
            f = exp_fall_q.pop_front();
            check("copy_done_edge", last, f);
            bad = 0;
            for (int k = NUM_REGS - 1; k >= 0; k--) if (regs_out[k] !== s[k]) bad = k;
            check($sformatf("snapshot x%0d", bad), regs_out[bad], s[bad]);
            check("changed_mask", changed_mask, m);
          end else begin
            check("init_busy_fall_edge", last, INIT_CYCLES - 1);
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : driver
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1);
    check("reset_mask", changed_mask, 0);
    check_all_zero("reset_regs");
    reset = 1'b0;
    model_reset();

    // INIT: a write and a frame start that must both be dropped
    for (int i = 0; i < INIT_CYCLES; i++)
      step(i == 3, 5'd9, 32'hBAD0_0009, i == 10, 1'b0);

    step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step(1'b1, 5'd3, 32'h0000_0011, 1'b0, 1'b0);
    step(1'b1, 5'd0, 32'h0000_1234, 1'b0, 1'b0);

    // Frame 1: collide with the read of x3 at T+4, stray frame start at T+10
    step(1'b0, '0, '0, 1'b1, 1'b0);
    for (int j = 1; j <= COPY_SPAN; j++) begin
      step(j == 4, 5'd3, 32'h0000_0022, j == 10, 1'b0);
      if (j == 7) check("x5_after_T_plus_7", regs_out[5], 32'hDEAD_BEEF);
      if (j == 10) check("busy_during_copy", busy, 1);
    end

    // Highlights of x5 age out after four accepted frames
    repeat (4) frame();
    check("x5_mask_5th_frame", changed_mask[5], 0);
    check("x3_final", regs_out[3], 32'h0000_0022);

    // Counter at 1 plus a write in the same cycle as frame start
    step(1'b1, 5'd7, 32'h0000_0077, 1'b0, 1'b0);
    repeat (3) frame();
    step(1'b1, 5'd7, 32'h0000_0078, 1'b1, 1'b0);
    idle(COPY_SPAN);
    check("x7_mask_reload", changed_mask[7], 1);
    repeat (5) frame();

    // Frozen frame start: nothing copied, mask held, write still tracked
    if (FRZ) begin
      step(1'b1, 5'd6, 32'h0000_0066, 1'b1, 1'b1);
      idle(3);
      check("freeze_no_copy", busy, 0);
      frame();
      frame();
    end

    // Reset in the middle of a copy
    step(1'b0, '0, '0, 1'b1, 1'b0);
    idle(12);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midcopy_reset_busy", busy, 1);
    check("midcopy_reset_mask", changed_mask, 0);
    check_all_zero("midcopy_reset_regs");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    idle(INIT_CYCLES);
    frame();

    // Randomised traffic
    for (int i = 0; i < 2500; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
           $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0);

    idle(COPY_SPAN + 4);
    check("scoreboard_drained", exp_fall_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
